zx_ps2_keyscan: RTL and testbench
=================================

# zx_ps2_keyscan

PS/2 keyboard front end for the ZX Spectrum core. It receives scan-code set 2 frames from a PS/2 keyboard and decodes make and break sequences. It then drives the single-key `code[6:0]`/`key_flag` pair that the ZX keyboard-matrix block reads. It is the producer end of that interface: one active key at a time, and the last make wins.

## Interface
- `FILTER_LEN`, default 8: clk cycles the synchronised ps2_clk must be stable before a level change is accepted.
- `TIMEOUT`, default 50000: clk cycles without a ps2_clk falling edge before a partial frame is abandoned.
- `clk` in 1: system clock. The block uses one clock.
- `reset` in 1: synchronous, active-high reset.
- `ps2_clk` in 1: raw PS/2 clock, asynchronous to clk.
- `ps2_data` in 1: raw PS/2 data, asynchronous to clk.
- `code` out 7: ZX key code of the last valid make.
- `key_flag` out 1: high while the key in `code` is held.
- `rx_err` out 1: one-cycle pulse when a frame is rejected.

## Operation
- **Input conditioning.** Both inputs pass through a 2-FF synchroniser. A ps2_clk glitch filter follows, with FILTER_LEN stable cycles required. A filtered falling edge creates a one-cycle `fall` strobe. The receiver samples ps2_data on `fall`.
- **Frame FSM.** States are IDLE, DATA, PARITY and STOP.
  - IDLE: on `fall` with data=0, go to DATA and clear `bitcnt`. If data=1, stay in IDLE; no error is flagged.
  - DATA: shift bits in LSB first. After the 8th bit, go to PARITY.
  - PARITY: store the parity bit. The frame is valid only if the 8 data bits plus parity hold an odd number of ones.
  - STOP: the stop bit must be 1. Return to IDLE. If parity and stop are good, raise `byte_valid` for 1 cycle; otherwise pulse `rx_err`.
  - Timeout: the timeout counter clears on every `fall` and only counts outside IDLE. When it reaches TIMEOUT, return to IDLE and pulse `rx_err`.
  - On any `rx_err`, clear the E0, F0 and pause-skip state.
- **Decoder.** It runs on `byte_valid`.
  - E0 sets `ext`. F0 sets `brk`. E1 loads `skip`=7, and the next 7 bytes are discarded (Pause sequence).
  - Any other byte is looked up in the base table, or in the extended table if `ext` is set. Afterwards, `ext` and `brk` are cleared.
  - Make of a mapped key: `code`<=map, `key_flag`<=1.
  - Break of a mapped key: if map equals `code`, `key_flag`<=0 and `code` holds its value. A break of any other key is ignored.
  - Unmapped bytes are ignored, including AA, FA, EE and FE.
  - Typematic repeats re-write the same value, so there is no visible change.
- **Base table (scan code -> ZX code).**
  - Digits: 45->00, 16->01, 1E->02, 26->03, 25->04, 2E->05, 36->06, 3D->07, 3E->08, 46->09.
  - Control keys: 29 (space)->0A, 5A (enter)->0B, 14 (LCtrl, symbol shift)->0C, 12/59 (shift, caps shift)->0D.
  - Letters A..Z map to 0E..27: 1C, 32, 21, 23, 24, 2B, 34, 33, 43, 3B, 42, 4B, 3A, 31, 44, 4D, 15, 2D, 1B, 2C, 3C, 2A, 1D, 22, 35, 1A.
  - Symbol combos: 55 (=)->30, 52 (')->31, 79 (kp +)->33, 4E/7B (-)->34.
  - Caps combos: 66 (backspace, DELETE)->40, 76 (esc, BREAK)->41.
  - Code 32 is never generated.
- **Extended table.** E0 14->0C, E0 5A->0B, E0 71->40.
- **Reset values.** `code`=00, `key_flag`=0, `rx_err`=0, FSM in IDLE, all counters and flags cleared. A reset mid-frame discards the partial byte with no `rx_err`.

## Timing
- Latency from the raw falling edge of the stop bit to an output change is exactly FILTER_LEN+4 clk cycles. This assumes ps2_data was stable for at least FILTER_LEN+2 cycles before that edge.
- `rx_err` is a single cycle, aligned with the cycle in which the outputs would have updated.
- If a make and a break fall in consecutive frames, each is applied in order. A second key's make overrides the first, and a later break of the first key leaves `key_flag` at 1.
- Timeout counter width: clog2(TIMEOUT+1). It saturates and does not wrap.

## Test plan
- Send frame 1C (A, parity 0), then F0, then 1C -> after the first frame `code`=0E and `key_flag`=1; after the 1C following F0, `key_flag`=0 and `code` stays 0E.
- Send 1C make, then 32 make (B), then F0 1C -> `code`=0F and `key_flag`=1 throughout the break of A.
- Send byte 16 with a wrong parity bit -> `rx_err` pulses once, and the outputs stay at 00/0. A following good 16 gives `code`=01, `key_flag`=1.
- Send E0 71, then E0 F0 71 -> `code`=40 with `key_flag` 1, then 0. Then send the full Pause sequence E1 14 77 E1 F0 14 F0 77 -> no output change and no symbol shift.
- Stop after 5 data bits and hold ps2_clk high for TIMEOUT cycles -> `rx_err` pulses and the FSM returns to IDLE. Assert `reset` mid-frame -> no `rx_err`, outputs 00/0, and the next full frame decodes correctly.
- Inject 3-cycle low glitches on ps2_clk with FILTER_LEN=8 -> no bits are sampled and the outputs are unchanged.

Source files
------------

// File: rtl/zx_ps2_keyscan_if.sv
// zx_ps2_keyscan_if: raw PS/2 lines in, single-key ZX code/flag and error pulse out.
interface zx_ps2_keyscan_if;
    logic       ps2_clk;
    logic       ps2_data;
    logic [6:0] code;
    logic       key_flag;
    logic       rx_err;
    modport master (input ps2_clk, ps2_data, output code, key_flag, rx_err);
    modport slave (output ps2_clk, ps2_data, input code, key_flag, rx_err);
endinterface

// File: rtl/zx_ps2_keyscan.sv
// zx_ps2_keyscan: PS/2 set-2 receiver and make/break decoder driving the ZX single-key code/flag pair.
module zx_ps2_keyscan #(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT = 50000
) (
    input logic clk,
    input logic reset,
    zx_ps2_keyscan_if.master bus
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic [1:0]    clk_sync_q, dat_sync_q;
    logic          filt_q, filt_d, fall_q, fall_d, accept;
    logic [FW-1:0] fcnt_q, fcnt_d;
    state_t        state_q, state_d;
    logic [7:0]    shreg_q, shreg_d;
    logic [2:0]    bitcnt_q, bitcnt_d;
    logic          par_q, par_d, bv_q, bv_d, ferr_q, ferr_d, din;
    logic [TW-1:0] to_q, to_d;
    logic [6:0]    code_q, code_d;
    logic          flag_q, flag_d, rx_err_q, ext_q, ext_d, brk_q, brk_d;
    logic [2:0]    skip_q, skip_d;
    logic [7:0]    lk;

    // {hit, zx_code}; hit=0 means the scan code has no ZX key
    function automatic logic [7:0] base_map(input logic [7:0] sc);
        case (sc)
            8'h45: base_map = {1'b1, 7'h00};
            8'h16: base_map = {1'b1, 7'h01};
            8'h1E: base_map = {1'b1, 7'h02};
            8'h26: base_map = {1'b1, 7'h03};
            8'h25: base_map = {1'b1, 7'h04};
            8'h2E: base_map = {1'b1, 7'h05};
            8'h36: base_map = {1'b1, 7'h06};
            8'h3D: base_map = {1'b1, 7'h07};
            8'h3E: base_map = {1'b1, 7'h08};
            8'h46: base_map = {1'b1, 7'h09};
            8'h29: base_map = {1'b1, 7'h0A};
            8'h5A: base_map = {1'b1, 7'h0B};
            8'h14: base_map = {1'b1, 7'h0C};
            8'h12: base_map = {1'b1, 7'h0D};
            8'h59: base_map = {1'b1, 7'h0D};
            8'h1C: base_map = {1'b1, 7'h0E};
            8'h32: base_map = {1'b1, 7'h0F};
            8'h21: base_map = {1'b1, 7'h10};
            8'h23: base_map = {1'b1, 7'h11};
            8'h24: base_map = {1'b1, 7'h12};
            8'h2B: base_map = {1'b1, 7'h13};
            8'h34: base_map = {1'b1, 7'h14};
            8'h33: base_map = {1'b1, 7'h15};
            8'h43: base_map = {1'b1, 7'h16};
            8'h3B: base_map = {1'b1, 7'h17};
            8'h42: base_map = {1'b1, 7'h18};
            8'h4B: base_map = {1'b1, 7'h19};
            8'h3A: base_map = {1'b1, 7'h1A};
            8'h31: base_map = {1'b1, 7'h1B};
            8'h44: base_map = {1'b1, 7'h1C};
            8'h4D: base_map = {1'b1, 7'h1D};
            8'h15: base_map = {1'b1, 7'h1E};
            8'h2D: base_map = {1'b1, 7'h1F};
            8'h1B: base_map = {1'b1, 7'h20};
            8'h2C: base_map = {1'b1, 7'h21};
            8'h3C: base_map = {1'b1, 7'h22};
            8'h2A: base_map = {1'b1, 7'h23};
            8'h1D: base_map = {1'b1, 7'h24};
            8'h22: base_map = {1'b1, 7'h25};
            8'h35: base_map = {1'b1, 7'h26};
            8'h1A: base_map = {1'b1, 7'h27};
            8'h55: base_map = {1'b1, 7'h30};
            8'h52: base_map = {1'b1, 7'h31};
            8'h79: base_map = {1'b1, 7'h33};
            8'h4E: base_map = {1'b1, 7'h34};
            8'h7B: base_map = {1'b1, 7'h34};
            8'h66: base_map = {1'b1, 7'h40};
            8'h76: base_map = {1'b1, 7'h41};
            default: base_map = 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] ext_map(input logic [7:0] sc);
        case (sc)
            8'h14: ext_map = {1'b1, 7'h0C};
            8'h5A: ext_map = {1'b1, 7'h0B};
            8'h71: ext_map = {1'b1, 7'h40};
            default: ext_map = 8'h00;
        endcase
    endfunction

    // ps2_clk must differ from the filtered level for FILTER_LEN straight cycles
    always_comb begin
        accept = clk_sync_q[1] != filt_q && fcnt_q == FW'(FILTER_LEN - 1);
        fcnt_d = (clk_sync_q[1] != filt_q && !accept) ? fcnt_q + FW'(1) : '0;
        filt_d = accept ? clk_sync_q[1] : filt_q;
        fall_d = accept && !clk_sync_q[1];
    end

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        bitcnt_d = bitcnt_q;
        par_d = par_q;
        bv_d = 1'b0;
        ferr_d = 1'b0;
        din = dat_sync_q[1];
        to_d = (fall_q || state_q == IDLE) ? '0 : (to_q == TW'(TIMEOUT) ? to_q : to_q + TW'(1));
        if (state_q != IDLE && to_q == TW'(TIMEOUT)) begin
            state_d = IDLE;
            ferr_d = 1'b1;
        end else if (fall_q) begin
            case (state_q)
                IDLE: begin
                    state_d = din ? IDLE : DATA;
                    bitcnt_d = '0;
                end
                DATA: begin
                    shreg_d = {din, shreg_q[7:1]};
                    bitcnt_d = bitcnt_q + 3'd1;
                    state_d = bitcnt_q == 3'd7 ? PARITY : DATA;
                end
                PARITY: begin
                    par_d = din;
                    state_d = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    bv_d = din && ^{shreg_q, par_q};
                    ferr_d = !(din && ^{shreg_q, par_q});
                end
            endcase
        end
    end

    always_comb begin
        lk = ext_q ? ext_map(shreg_q) : base_map(shreg_q);
        code_d = code_q;
        flag_d = flag_q;
        ext_d = ext_q;
        brk_d = brk_q;
        skip_d = skip_q;
        if (ferr_q) begin
            ext_d = 1'b0;
            brk_d = 1'b0;
            skip_d = '0;
        end else if (bv_q) begin
            if (skip_q != 3'd0) begin
                skip_d = skip_q - 3'd1;
            end else if (shreg_q == 8'hE0) begin
                ext_d = 1'b1;
            end else if (shreg_q == 8'hF0) begin
                brk_d = 1'b1;
            end else if (shreg_q == 8'hE1) begin
                skip_d = 3'd7;
            end else begin
                ext_d = 1'b0;
                brk_d = 1'b0;
                code_d = (lk[7] && !brk_q) ? lk[6:0] : code_q;
                flag_d = !lk[7] ? flag_q : (!brk_q ? 1'b1 : (lk[6:0] == code_q ? 1'b0 : flag_q));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
            filt_q <= 1'b1;
            fcnt_q <= '0;
            fall_q <= 1'b0;
            state_q <= IDLE;
            shreg_q <= '0;
            bitcnt_q <= '0;
            par_q <= 1'b0;
            to_q <= '0;
            bv_q <= 1'b0;
            ferr_q <= 1'b0;
            code_q <= '0;
            flag_q <= 1'b0;
            rx_err_q <= 1'b0;
            ext_q <= 1'b0;
            brk_q <= 1'b0;
            skip_q <= '0;
        end else begin
            clk_sync_q <= {clk_sync_q[0], bus.ps2_clk};
            dat_sync_q <= {dat_sync_q[0], bus.ps2_data};
            filt_q <= filt_d;
            fcnt_q <= fcnt_d;
            fall_q <= fall_d;
            state_q <= state_d;
            shreg_q <= shreg_d;
            bitcnt_q <= bitcnt_d;
            par_q <= par_d;
            to_q <= to_d;
            bv_q <= bv_d;
            ferr_q <= ferr_d;
            code_q <= code_d;
            flag_q <= flag_d;
            rx_err_q <= ferr_q;
            ext_q <= ext_d;
            brk_q <= brk_d;
            skip_q <= skip_d;
        end
    end

    assign bus.code = code_q;
    assign bus.key_flag = flag_q;
    assign bus.rx_err = rx_err_q;
endmodule

// File: tb/tb_zx_ps2_keyscan.sv
// tb_zx_ps2_keyscan: directed PS/2 frames with a timestamped scoreboard of expected output events.
module tb_zx_ps2_keyscan;
    localparam int F = 8;
    localparam int T = 200;
    localparam int H = 20;

    typedef struct {
        logic       err;
        logic [6:0] code;
        logic       flag;
        int         lo;
        int         hi;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int cyc = 0;
    int checks = 0;
    int failures = 0;
    int last_fall = 0;
    exp_t q[$];

    zx_ps2_keyscan_if bus();
    zx_ps2_keyscan #(.FILTER_LEN(F), .TIMEOUT(T)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic expect_ev(input logic err, input logic [6:0] c, input logic f, input int lo, input int hi);
        exp_t e;
        e.err = err;
        e.code = c;
        e.flag = f;
        e.lo = lo;
        e.hi = hi;
        q.push_back(e);
    endtask

    task automatic ps2_bit(input logic b);
        bus.ps2_data = b;
        repeat (H) @(negedge clk);
        bus.ps2_clk = 1'b0;
        last_fall = cyc;
        repeat (H) @(negedge clk);
        bus.ps2_clk = 1'b1;
    endtask

    // kind: 0 no visible change, 1 output update to c/f, 2 rx_err pulse
    task automatic send_frame(input logic [7:0] b, input logic bad_par, input int kind, input logic [6:0] c, input logic f);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(~^b ^ bad_par);
        bus.ps2_data = 1'b1;
        repeat (H) @(negedge clk);
        bus.ps2_clk = 1'b0;
        if (kind != 0) expect_ev(kind == 2, c, f, cyc + F + 4, cyc + F + 4);
        repeat (H) @(negedge clk);
        bus.ps2_clk = 1'b1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic check_out(input string name, input logic [6:0] c, input logic f);
        checks++;
        if (bus.code !== c || bus.key_flag !== f || bus.rx_err !== 1'b0 || q.size() != 0) begin
            failures++;
            $display("FAIL %s: got code=%02h flag=%0b rx_err=%0b pending=%0d, expected code=%02h flag=%0b rx_err=0 pending=0",
                     name, bus.code, bus.key_flag, bus.rx_err, q.size(), c, f);
        end
    endtask

    task automatic take_ev(input logic err);
        exp_t e;
        checks++;
        if (q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_event: got err=%0b code=%02h flag=%0b cyc=%0d, expected no event",
                     err, bus.code, bus.key_flag, cyc);
        end else begin
            e = q.pop_front();
            if (e.err !== err || (!err && (bus.code !== e.code || bus.key_flag !== e.flag)) || cyc < e.lo || cyc > e.hi) begin
                failures++;
                $display("FAIL event: got err=%0b code=%02h flag=%0b cyc=%0d, expected err=%0b code=%02h flag=%0b cyc=%0d..%0d",
                         err, bus.code, bus.key_flag, cyc, e.err, e.code, e.flag, e.lo, e.hi);
            end
        end
    endtask

    initial begin
        logic [6:0] prev_code;
        logic prev_flag;
        prev_code = '0;
        prev_flag = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (bus.rx_err) take_ev(1'b1);
                if (bus.code !== prev_code || bus.key_flag !== prev_flag) take_ev(1'b0);
            end
            prev_code = bus.code;
            prev_flag = bus.key_flag;
        end
    end

    initial begin
        bus.ps2_clk = 1'b1;
        bus.ps2_data = 1'b1;
        @(negedge clk);
        do_reset();
        repeat (5) @(negedge clk);
        check_out("reset_state", 7'h00, 1'b0);
        // make A, break A
        send_frame(8'h1C, 1'b0, 1, 7'h0E, 1'b1);
        send_frame(8'hF0, 1'b0, 0, 7'h00, 1'b0);
        send_frame(8'h1C, 1'b0, 1, 7'h0E, 1'b0);
        // last make wins; stale break of A is ignored
        send_frame(8'h1C, 1'b0, 1, 7'h0E, 1'b1);
        send_frame(8'h32, 1'b0, 1, 7'h0F, 1'b1);
        send_frame(8'hF0, 1'b0, 0, 7'h00, 1'b0);
        send_frame(8'h1C, 1'b0, 0, 7'h00, 1'b0);
        repeat (30) @(negedge clk);
        check_out("break_other_key", 7'h0F, 1'b1);
        send_frame(8'hF0, 1'b0, 0, 7'h00, 1'b0);
        send_frame(8'h32, 1'b0, 1, 7'h0F, 1'b0);
        // parity error then good frame
        do_reset();
        repeat (5) @(negedge clk);
        check_out("reset_again", 7'h00, 1'b0);
        send_frame(8'h16, 1'b1, 2, 7'h00, 1'b0);
        send_frame(8'h16, 1'b0, 1, 7'h01, 1'b1);
        // extended key and the Pause sequence
        send_frame(8'hE0, 1'b0, 0, 7'h00, 1'b0);
        send_frame(8'h71, 1'b0, 1, 7'h40, 1'b1);
        send_frame(8'hE0, 1'b0, 0, 7'h00, 1'b0);
        send_frame(8'hF0, 1'b0, 0, 7'h00, 1'b0);
        send_frame(8'h71, 1'b0, 1, 7'h40, 1'b0);
        send_frame(8'hE1, 1'b0, 0, 7'h00, 1'b0);
        send_frame(8'h14, 1'b0, 0, 7'h00, 1'b0);
        send_frame(8'h77, 1'b0, 0, 7'h00, 1'b0);
        send_frame(8'hE1, 1'b0, 0, 7'h00, 1'b0);
        send_frame(8'hF0, 1'b0, 0, 7'h00, 1'b0);
        send_frame(8'h14, 1'b0, 0, 7'h00, 1'b0);
        send_frame(8'hF0, 1'b0, 0, 7'h00, 1'b0);
        send_frame(8'h77, 1'b0, 0, 7'h00, 1'b0);
        repeat (30) @(negedge clk);
        check_out("after_pause", 7'h40, 1'b0);
        // typematic repeat and unmapped byte
        send_frame(8'h16, 1'b0, 1, 7'h01, 1'b1);
        send_frame(8'h16, 1'b0, 0, 7'h00, 1'b0);
        send_frame(8'hAA, 1'b0, 0, 7'h00, 1'b0);
        repeat (30) @(negedge clk);
        check_out("repeat_unmapped", 7'h01, 1'b1);
        // partial frame abandoned by timeout
        ps2_bit(1'b0);
        for (int i = 0; i < 5; i++) ps2_bit(1'b1);
        bus.ps2_data = 1'b1;
        expect_ev(1'b1, 7'h00, 1'b0, last_fall + T, last_fall + T + F + 12);
        repeat (T + 60) @(negedge clk);
        send_frame(8'h2E, 1'b0, 1, 7'h05, 1'b1);
        // reset in the middle of a frame
        ps2_bit(1'b0);
        for (int i = 0; i < 3; i++) ps2_bit(1'b0);
        bus.ps2_data = 1'b1;
        do_reset();
        repeat (5) @(negedge clk);
        check_out("reset_mid_frame", 7'h00, 1'b0);
        send_frame(8'h1C, 1'b0, 1, 7'h0E, 1'b1);
        // short low glitches with data low must not start a frame
        bus.ps2_data = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.ps2_clk = 1'b0;
            repeat (3) @(negedge clk);
            bus.ps2_clk = 1'b1;
            repeat (H) @(negedge clk);
        end
        bus.ps2_data = 1'b1;
        repeat (T + 50) @(negedge clk);
        check_out("glitch_reject", 7'h0E, 1'b1);
        send_frame(8'hF0, 1'b0, 0, 7'h00, 1'b0);
        send_frame(8'h1C, 1'b0, 1, 7'h0E, 1'b0);
        repeat (50) @(negedge clk);
        check_out("final_state", 7'h0E, 1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
